// File: rtl/uart_viterbi_decode_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_viterbi_decode_ctrl_if
//
// Byte-stream handshake between the Viterbi decode controller and the UART
// pair in the board top.
//
//   rx_data  [7:0]  byte from the UART receiver
//   rx_valid        one-cycle strobe qualifying rx_data
//   tx_busy         UART transmitter busy
//   tx_data  [7:0]  byte to transmit, held from tx_start until tx_busy falls
//   tx_start        one-cycle transmit request
//
// Modports:
//   master - the decode controller (consumes rx, issues tx requests)
//   slave  - the UART receiver/transmitter side
// ---------------------------------------------------------------------------
interface uart_viterbi_decode_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;

    modport master (
        input  rx_data,
        input  rx_valid,
        input  tx_busy,
        output tx_data,
        output tx_start
    );

    modport slave (
        output rx_data,
        output rx_valid,
        output tx_busy,
        input  tx_data,
        input  tx_start
    );
endinterface

// File: rtl/uart_viterbi_decode_ctrl.sv
// ---------------------------------------------------------------------------
// uart_viterbi_decode_ctrl
//
// Receive-side partner of the K=3, rate-1/2 (7,5 octal) convolutional
// encoder. Collects an 8-byte encoded frame (32 symbol pairs) from the UART
// receiver, runs a hard-decision Viterbi decoder starting in state 0, and
// sends the 4 decoded bytes back through the UART transmitter handshake.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   abort       one-cycle clear request, same effect as rst
//   bus         uart_viterbi_decode_ctrl_if.master (rx_data, rx_valid,
//               tx_busy in; tx_data, tx_start out)
//   busy        high while decoding, tracing back or sending
//   frame_drop  one-cycle pulse when a byte arrives while busy (byte dropped)
//   err_count   [7:0] minimum final path metric of the last frame
//               (only when VITERBI_ERR_COUNT_EN is defined)
//
// Optional feature macro: VITERBI_ERR_COUNT_EN
//
// Encoder model: state s = {s1,s0}, s0 = previous input bit.
//   g0 = b^s0^s1, g1 = b^s1, next state = {s0,b}.
// Symbol pair k lives in frame[2k+1:2k] as {g0,g1}.
// ---------------------------------------------------------------------------
module uart_viterbi_decode_ctrl #(
    parameter int PM_W        = 6,
    parameter int FRAME_BYTES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic abort,
    uart_viterbi_decode_ctrl_if.master bus,
    output logic busy,
    output logic frame_drop
`ifdef VITERBI_ERR_COUNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int NSTEPS    = 4 * FRAME_BYTES;     // symbol pairs per frame
    localparam int STEP_W    = $clog2(NSTEPS);
    localparam int CNT_W     = $clog2(FRAME_BYTES);
    localparam int OUT_BYTES = FRAME_BYTES / 2;
    localparam int IDX_W     = $clog2(OUT_BYTES);
    localparam int WORD_W    = NSTEPS;

    localparam logic [2:0] ST_COLLECT   = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_TRACE     = 3'd2;
    localparam logic [2:0] ST_SEND_IDLE = 3'd3;
    localparam logic [2:0] ST_SEND_GAP  = 3'd4;
    localparam logic [2:0] ST_SEND_WAIT = 3'd5;

    localparam logic [PM_W-1:0] PM_MAX = {PM_W{1'b1}};

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic logic [1:0] hamming2(input logic [1:0] d);
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                                 input logic [1:0]      b);
        logic [PM_W:0] s;
        s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
        return s[PM_W] ? PM_MAX : s[PM_W-1:0];
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [2:0]                  state_reg;
    logic [CNT_W-1:0]            byte_cnt_reg;
    logic [8*FRAME_BYTES-1:0]    frame_reg;
    logic [STEP_W-1:0]           step_reg;
    logic [3:0][PM_W-1:0]        pm_reg;
    logic [3:0][PM_W-1:0]        pm_next;
    logic [3:0]                  dec_vec;
    logic [3:0]                  dec_last_reg;
    logic [3:0]                  surv_rd_reg;
    logic [3:0]                  surv_mem [NSTEPS];
    logic [STEP_W-1:0]           rd_addr;
    logic [3:0]                  dec_sel;
    logic [1:0]                  trace_state_reg;
    logic [1:0]                  trace_state_next;
    logic [1:0]                  best_state;
    logic [PM_W-1:0]             best_metric;
    logic [WORD_W-1:0]           word_reg;
    logic [WORD_W-1:0]           word_next;
    logic [IDX_W-1:0]            byte_idx_reg;
    logic [7:0]                  tx_data_reg;
    logic                        frame_drop_reg;
    logic                        clear;
    logic                        in_busy;
    logic [1:0]                  rx_pair;
`ifdef VITERBI_ERR_COUNT_EN
    logic [7:0]                  err_count_reg;
`endif

    assign clear   = rst | abort;
    assign in_busy = (state_reg != ST_COLLECT);
    assign rx_pair = frame_reg[2*step_reg +: 2];

    // -----------------------------------------------------------------------
    // Add-compare-select, one butterfly per next state.
    // Next state {a,b} is reached with input b from predecessors {0,a} and
    // {1,a}; the decision bit records which s1 was kept (0 wins ties).
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_acs
            localparam logic       A    = 1'((gi >> 1) & 1);
            localparam logic       B    = 1'(gi & 1);
            localparam logic [1:0] EXP0 = {A ^ B, B};   // {g0,g1} via s1=0
            localparam logic [1:0] EXP1 = EXP0 ^ 2'b11; // {g0,g1} via s1=1

            logic [PM_W-1:0] cand0;
            logic [PM_W-1:0] cand1;

            assign cand0         = sat_add(pm_reg[{1'b0, A}], hamming2(EXP0 ^ rx_pair));
            assign cand1         = sat_add(pm_reg[{1'b1, A}], hamming2(EXP1 ^ rx_pair));
            assign dec_vec[gi]   = (cand1 < cand0);
            assign pm_next[gi]   = dec_vec[gi] ? cand1 : cand0;
        end
    endgenerate

    // Best final state: strict compare keeps the lowest index on ties.
    always_comb begin
        best_state  = 2'd0;
        best_metric = pm_next[0];
        for (int i = 1; i < 4; i++) begin
            if (pm_next[i] < best_metric) begin
                best_metric = pm_next[i];
                best_state  = 2'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Traceback. The survivor RAM has a registered read, so the read for
    // step k-1 is issued while step k is processed. The newest step (31) is
    // still being written when tracing starts, so its decisions come from a
    // bypass register instead of the RAM.
    // -----------------------------------------------------------------------
    assign rd_addr = step_reg - 1'b1;

    always_comb begin
        dec_sel          = (step_reg == STEP_W'(NSTEPS-1)) ? dec_last_reg : surv_rd_reg;
        trace_state_next = {dec_sel[trace_state_reg], trace_state_reg[1]};
        // Bits are produced newest first; shifting left lands bit k at word[k].
        word_next        = {word_reg[WORD_W-2:0], trace_state_reg[0]};
    end

    // Survivor memory: 32 x 4 decision bits, no reset.
    always_ff @(posedge clk) begin
        if (state_reg == ST_DECODE) begin
            surv_mem[step_reg] <= dec_vec;
        end
        surv_rd_reg <= surv_mem[rd_addr];
    end

    // -----------------------------------------------------------------------
    // Control FSM and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg       <= ST_COLLECT;
            byte_cnt_reg    <= '0;
            frame_reg       <= '0;
            step_reg        <= '0;
            pm_reg          <= '0;
            dec_last_reg    <= '0;
            trace_state_reg <= '0;
            word_reg        <= '0;
            byte_idx_reg    <= '0;
            tx_data_reg     <= '0;
            frame_drop_reg  <= 1'b0;
`ifdef VITERBI_ERR_COUNT_EN
            err_count_reg   <= '0;
`endif
        end else begin
            frame_drop_reg <= bus.rx_valid && in_busy;

            case (state_reg)
                ST_COLLECT: begin
                    if (bus.rx_valid) begin
                        frame_reg[8*byte_cnt_reg +: 8] <= bus.rx_data;
                        if (byte_cnt_reg == CNT_W'(FRAME_BYTES-1)) begin
                            byte_cnt_reg <= '0;
                            step_reg     <= '0;
                            // Encoder starts in state 0.
                            pm_reg       <= {PM_MAX, PM_MAX, PM_MAX, {PM_W{1'b0}}};
                            state_reg    <= ST_DECODE;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        end
                    end
                end

                ST_DECODE: begin
                    pm_reg       <= pm_next;
                    dec_last_reg <= dec_vec;
                    if (step_reg == STEP_W'(NSTEPS-1)) begin
                        // step_reg already points at the first traceback step.
                        trace_state_reg <= best_state;
`ifdef VITERBI_ERR_COUNT_EN
                        err_count_reg   <= 8'(best_metric);
`endif
                        state_reg       <= ST_TRACE;
                    end else begin
                        step_reg <= step_reg + 1'b1;
                    end
                end

                ST_TRACE: begin
                    trace_state_reg <= trace_state_next;
                    word_reg        <= word_next;
                    if (step_reg == '0) begin
                        byte_idx_reg <= '0;
                        tx_data_reg  <= word_next[7:0];
                        state_reg    <= ST_SEND_IDLE;
                    end else begin
                        step_reg <= step_reg - 1'b1;
                    end
                end

                ST_SEND_IDLE: begin
                    // tx_start is raised combinationally in this state.
                    if (!bus.tx_busy) begin
                        state_reg <= ST_SEND_GAP;
                    end
                end

                ST_SEND_GAP: begin
                    // Give the transmitter one cycle to raise tx_busy.
                    state_reg <= ST_SEND_WAIT;
                end

                ST_SEND_WAIT: begin
                    if (!bus.tx_busy) begin
                        if (byte_idx_reg == IDX_W'(OUT_BYTES-1)) begin
                            state_reg <= ST_COLLECT;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 1'b1;
                            tx_data_reg  <= word_reg[8*(byte_idx_reg+1) +: 8];
                            state_reg    <= ST_SEND_IDLE;
                        end
                    end
                end

                default: state_reg <= ST_COLLECT;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Gated by clear so an abort in the issuing cycle suppresses the request.
    assign bus.tx_start = (state_reg == ST_SEND_IDLE) && !bus.tx_busy && !clear;
    assign bus.tx_data  = tx_data_reg;
    assign busy         = in_busy;
    assign frame_drop   = frame_drop_reg;
`ifdef VITERBI_ERR_COUNT_EN
    assign err_count    = err_count_reg;
`endif

endmodule

// File: tb/tb_uart_viterbi_decode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_viterbi_decode_ctrl
//
// Directed bench for uart_viterbi_decode_ctrl: hand-encoded frames with
// hand-decoded expected bytes, a simple transmitter busy model, dropped-byte
// and abort scenarios. err_count is checked when VITERBI_ERR_COUNT_EN is
// defined.
// ---------------------------------------------------------------------------
module tb_uart_viterbi_decode_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic abort;
    logic busy;
    logic frame_drop;
`ifdef VITERBI_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    uart_viterbi_decode_ctrl_if vif ();

    uart_viterbi_decode_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .abort      (abort),
        .bus        (vif),
        .busy       (busy),
        .frame_drop (frame_drop)
`ifdef VITERBI_ERR_COUNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor (only writer of these) ----------------
    logic [7:0] tx_q[$];
    int         start_cyc[$];
    int         drop_cnt     = 0;
    int         unstable_cnt = 0;
    logic [7:0] held_data    = 8'h00;

    always @(negedge clk) begin
        if (vif.tx_start) begin
            tx_q.push_back(vif.tx_data);
            start_cyc.push_back(cyc);
            held_data = vif.tx_data;
        end
        if (frame_drop) drop_cnt++;
        if (vif.tx_busy && (vif.tx_data !== held_data)) unstable_cnt++;
    end

    // ---------------- transmitter model ----------------
    int busy_len = 0;

    initial begin
        vif.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (vif.tx_start && busy_len > 0) begin
                @(posedge clk);
                #1 vif.tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 vif.tx_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, output int v_cyc);
        @(posedge clk);
        #1;
        vif.rx_data  = b;
        vif.rx_valid = 1'b1;
        v_cyc        = cyc;
        @(posedge clk);
        #1 vif.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int t = 0; t < 600 && busy; t++) @(negedge clk);
        @(negedge clk);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic run_frame(input string name, input logic [63:0] frame,
                             input logic [31:0] exp_word, input int exp_err,
                             input int blen, input bit inject_drop);
        int         base_tx;
        int         base_drop;
        int         base_unst;
        int         v_cyc;
        int         last_cyc;
        logic [7:0] got;
        int         lat;
        int         gap;
        logic [7:0] b;

        busy_len  = blen;
        base_tx   = tx_q.size();
        base_drop = drop_cnt;
        base_unst = unstable_cnt;
        last_cyc  = 0;
        for (int j = 0; j < 8; j++) begin
            b = frame[8*j +: 8];
            send_byte(b, v_cyc);
            last_cyc = v_cyc;
        end
        if (inject_drop) begin
            repeat (3) @(posedge clk);
            send_byte(8'hAA, v_cyc);
        end
        for (int t = 0; t < 2000 && (tx_q.size() - base_tx) < 4; t++) @(posedge clk);
        wait_idle(name);
        repeat (3) @(negedge clk);

        check({name, "_txcount"}, 64'(tx_q.size() - base_tx), 64'd4);
        for (int j = 0; j < 4; j++) begin
            got = 8'hxx;
            if (base_tx + j < tx_q.size()) got = tx_q[base_tx + j];
            check($sformatf("%s_byte%0d", name, j), 64'(got), 64'(exp_word[8*j +: 8]));
        end
        lat = -1;
        if (base_tx < start_cyc.size()) lat = start_cyc[base_tx] - last_cyc;
        check({name, "_latency"}, 64'(lat), 64'd65);
        if (blen > 0) begin
            for (int j = 1; j < 4; j++) begin
                gap = -1;
                if (base_tx + j < start_cyc.size())
                    gap = start_cyc[base_tx + j] - start_cyc[base_tx + j - 1];
                check($sformatf("%s_gap%0d", name, j), 64'(gap), 64'(blen + 2));
            end
        end
        check({name, "_drops"}, 64'(drop_cnt - base_drop), 64'(inject_drop ? 1 : 0));
        check({name, "_txdata_stable"}, 64'(unstable_cnt - base_unst), 64'd0);
`ifdef VITERBI_ERR_COUNT_EN
        check({name, "_err_count"}, 64'(err_count), 64'(exp_err));
`else
        if (exp_err < 0) $display("note: negative expected error count for %s", name);
`endif
        $display("frame %s: rx %016h -> tx %02h %02h %02h %02h (expected %08h)", name, frame,
                 (base_tx + 0 < tx_q.size()) ? tx_q[base_tx + 0] : 8'h00,
                 (base_tx + 1 < tx_q.size()) ? tx_q[base_tx + 1] : 8'h00,
                 (base_tx + 2 < tx_q.size()) ? tx_q[base_tx + 2] : 8'h00,
                 (base_tx + 3 < tx_q.size()) ? tx_q[base_tx + 3] : 8'h00, exp_word);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int base_tx;
        int v_cyc;

        rst          = 1'b1;
        abort        = 1'b0;
        vif.rx_data  = 8'h00;
        vif.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",       64'(busy),         64'd0);
        check("reset_tx_start",   64'(vif.tx_start), 64'd0);
        check("reset_tx_data",    64'(vif.tx_data),  64'd0);
        check("reset_frame_drop", 64'(frame_drop),   64'd0);
`ifdef VITERBI_ERR_COUNT_EN
        check("reset_err_count",  64'(err_count),    64'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        run_frame("zeros",     64'h0000_0000_0000_0000, 32'h0000_0000, 0, 0,   1'b0);
        run_frame("bit0",      64'h0000_0000_0000_003B, 32'h0000_0001, 0, 0,   1'b0);
        run_frame("bits01",    64'h0000_0000_0000_00D7, 32'h0000_0003, 0, 0,   1'b0);
        run_frame("one_error", 64'h0000_0000_4000_0000, 32'h0000_0000, 1, 0,   1'b0);
        run_frame("bit31",     64'hC000_0000_0000_0000, 32'h8000_0000, 0, 0,   1'b0);
        run_frame("bit30",     64'hB000_0000_0000_0000, 32'h4000_0000, 0, 0,   1'b0);
        run_frame("slow_tx",   64'h0000_0000_0000_003B, 32'h0000_0001, 0, 100, 1'b0);
        run_frame("drop",      64'h0000_0000_0000_0000, 32'h0000_0000, 0, 0,   1'b1);

        // Abort during traceback: frame abandoned, nothing sent.
        busy_len = 0;
        base_tx  = tx_q.size();
        for (int j = 0; j < 8; j++) send_byte((j == 0) ? 8'h3B : 8'h00, v_cyc);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("abort_pre_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        repeat (100) @(negedge clk);
        check("abort_no_tx",   64'(tx_q.size() - base_tx), 64'd0);
        check("abort_busy",    64'(busy),                  64'd0);
        check("abort_tx_data", 64'(vif.tx_data),           64'd0);
`ifdef VITERBI_ERR_COUNT_EN
        check("abort_err_count", 64'(err_count), 64'd0);
`endif
        $display("abort during traceback: %0d tx_start after abort", tx_q.size() - base_tx);
        run_frame("after_abort", 64'h0000_0000_0000_00D7, 32'h0000_0003, 0, 0, 1'b0);

        // Partial frame, then abort together with rx_valid: count restarts
        // and the coincident byte is discarded.
        for (int j = 0; j < 3; j++) send_byte(8'hFF, v_cyc);
        @(posedge clk);
        #1;
        abort        = 1'b1;
        vif.rx_data  = 8'hFF;
        vif.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        abort        = 1'b0;
        vif.rx_valid = 1'b0;
        $display("partial frame of 3 bytes aborted together with rx_valid");
        run_frame("after_partial", 64'h0000_0000_0000_003B, 32'h0000_0001, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_viterbi_decode_ctrl.md
Name: uart_viterbi_decode_ctrl

Overview:
- Receive-side counterpart of the K=3, rate-1/2 convolutional encode path.
- Collects one 8-byte encoded frame from the UART receiver, which carries 32 symbol pairs.
- Runs a built-in hard-decision Viterbi decoder over the frame, with generators 7/5 octal and start state 0.
- Returns the 4 decoded bytes through the UART transmitter handshake. Sits between async_receiver and async_transmitter in the board top.

Parameters:
- PM_W, 6, path-metric register width; metrics saturate at 2^PM_W-1.
- FRAME_BYTES, 8, encoded bytes per frame; fixed at 8, and any other value is unsupported.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- abort  in  1  debounced clear request; same effect as rst, one cycle wide
- rx_data  in  8  byte from the UART receiver
- rx_valid  in  1  one-cycle strobe; rx_data is valid
- tx_busy  in  1  UART transmitter busy
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_busy falls
- tx_start  out  1  one-cycle transmit request
- busy  out  1  high in DECODE, TRACE and SEND
- frame_drop  out  1  one-cycle pulse when an rx_valid arrives while busy

Behaviour:
- Reset (rst or abort): state=COLLECT, byte count=0, metrics cleared, all outputs 0 (tx_data=0x00). Reset mid-DECODE, TRACE or SEND abandons the frame, and no further tx_start is issued.
- Frame layout: received byte i fills frame[8i+7:8i]; byte 0 arrives first.
- Symbol pair k = frame[2k+1:2k], with bit 2k+1 = g0 and bit 2k = g1.
- Encoder definition: state s = {s1,s0}, where s0 is the previous bit and s1 the bit before it. g0 = b^s0^s1 and g1 = b^s1. Next state = {s0,b}.
- COLLECT: each rx_valid stores a byte. On the 8th byte, sampled in cycle N, go to DECODE in cycle N+1.
- DECODE (cycles N+1..N+32): one add-compare-select step per cycle, for pair k=0..31.
  - Branch metric = Hamming distance (0..2) between the received pair and the expected pair.
  - Initial metrics: state 0 = 0, states 1-3 = max value.
  - Adds saturate.
  - Ties select the predecessor with s1=0.
  - One decision bit per state per step is written to a 32x4 survivor memory.
- TRACE (cycles N+33..N+64):
  - Start state = state with the minimum final metric; ties go to the lowest index.
  - Walk k=31 down to 0. The decoded bit k = s0 of the current state, i.e. the newest input bit. The predecessor comes from the decision bit.
  - Decoded bit k lands in word[k]; byte j = word[8j+7:8j].
  - No tail bits are assumed.
- SEND: 4 bytes go out, byte 0 first.
  - For each byte: when tx_busy=0, drive tx_data and pulse tx_start for 1 cycle.
  - Then wait one cycle, then wait for tx_busy=0.
  - The first tx_start occurs at N+65 if tx_busy=0; otherwise it is stalled until tx_busy=0.
  - After byte 3's tx_busy falls, return to COLLECT with byte count=0.
- rx_valid while busy: the byte is discarded and frame_drop pulses. The frame in progress is unaffected.
- abort and rx_valid in the same cycle: abort wins and the byte is discarded.
- The minimum final metric equals the number of corrected channel bit errors, saturating.

Optional Feature:
- Macro: VITERBI_ERR_COUNT_EN.
- When defined:
  - Adds output err_count [7:0]: the minimum final path metric, zero-extended, latched at the end of DECODE.
  - err_count holds until the next frame's DECODE end, and is cleared by rst/abort.
- When undefined:
  - The port is absent.
  - The behaviour of every other port is identical.

Test Plan:
- rx 00 00 00 00 00 00 00 00, tx_busy held 0 -> tx 00 00 00 00. First tx_start exactly 65 cycles after the 8th rx_valid. err_count=0.
- rx 3B 00 00 00 00 00 00 00 -> tx 01 00 00 00; err_count=0.
- rx 00 00 00 40 00 00 00 00 (one flipped bit) -> tx 00 00 00 00; err_count=1.
- Transmitter model holds tx_busy high 100 cycles per byte -> exactly 4 tx_start pulses, each issued only after tx_busy falls. tx_data stable while busy.
- Extra rx_valid (0xAA) during DECODE -> frame_drop pulses once and the output is unchanged.
- abort asserted in TRACE -> no tx_start. The next clean 8-byte frame decodes correctly.
